// File: rtl/semaforo_pkg.sv
// Shared definitions for the semaforo lamp monitor: lamp bit positions, fault codes,
// monitor states and the per-direction phase decode.
package semaforo_pkg;

  // Bit positions in the 8-bit lamp bus {ped_b,ped_a,g_b,y_b,r_b,g_a,y_a,r_a}
  localparam int unsigned LAMP_R_A   = 0;
  localparam int unsigned LAMP_Y_A   = 1;
  localparam int unsigned LAMP_G_A   = 2;
  localparam int unsigned LAMP_R_B   = 3;
  localparam int unsigned LAMP_Y_B   = 4;
  localparam int unsigned LAMP_G_B   = 5;
  localparam int unsigned LAMP_PED_A = 6;
  localparam int unsigned LAMP_PED_B = 7;

  // Numeric value doubles as priority: lowest non-zero code wins
  typedef enum logic [2:0] {
    FC_NONE     = 3'd0,
    FC_CONFLICT = 3'd1,
    FC_COMBO    = 3'd2,
    FC_PED      = 3'd3,
    FC_SEQ      = 3'd4,
    FC_SHORT    = 3'd5,
    FC_STALL    = 3'd6
  } fault_code_t;

  typedef logic [1:0] mon_state_t;
  localparam mon_state_t ST_INIT  = 2'd0;
  localparam mon_state_t ST_RUN   = 2'd1;
  localparam mon_state_t ST_FAULT = 2'd2;

  typedef enum logic [1:0] {PH_R, PH_Y, PH_G, PH_BAD} phase_t;

  // ryg = {g,y,r}; anything not one-hot is PH_BAD
  function automatic phase_t decode_phase(input logic [2:0] ryg);
    phase_t ph;
    case (ryg)
      3'b001:  ph = PH_R;
      3'b010:  ph = PH_Y;
      3'b100:  ph = PH_G;
      default: ph = PH_BAD;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/semaforo_phase_tracker.sv
// One traffic direction: detects phase changes, checks legal order (G->Y->R->G),
// minimum green/yellow durations, and owns the saturating phase tick counter.
module semaforo_phase_tracker
  import semaforo_pkg::*;
#(
  parameter int unsigned MIN_GREEN  = 8,
  parameter int unsigned MIN_YELLOW = 2,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       tick,
  input  logic [2:0] ryg_now,
  input  logic [2:0] ryg_prev,
  output logic       changed,
  output logic       seq_err,
  output logic       short_err,
  output logic       combo_err
);

  localparam logic [CNT_W-1:0] MinGreenCnt  = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] MinYellowCnt = CNT_W'(MIN_YELLOW);

  phase_t           ph_now;
  phase_t           ph_prev;
  logic [CNT_W-1:0] phase_cnt;

  // Transition legality and duration checks against the ticks spent in the old phase
  always_comb begin
    ph_now    = decode_phase(ryg_now);
    ph_prev   = decode_phase(ryg_prev);
    changed   = (ryg_now != ryg_prev);
    combo_err = (ph_now == PH_BAD);
    seq_err   = changed && !((ph_prev == PH_G && ph_now == PH_Y) ||
                             (ph_prev == PH_Y && ph_now == PH_R) ||
                             (ph_prev == PH_R && ph_now == PH_G));
    short_err = changed && ((ph_prev == PH_G && phase_cnt < MinGreenCnt) ||
                            (ph_prev == PH_Y && phase_cnt < MinYellowCnt));
  end

  // Phase counter: a change in the same cycle as a tick restarts from zero
  always_ff @(posedge clk) begin
    if (reset || clear || changed) begin
      phase_cnt <= '0;
    end else if (tick && phase_cnt != '1) begin
      phase_cnt <= phase_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/semaforo_monitor.sv
// Protocol checker for the semaforo lamp outputs. Registers the lamp bus, runs static,
// sequence, duration and progress checks while armed, and latches the first violation.
module semaforo_monitor
  import semaforo_pkg::*;
#(
  parameter int unsigned MIN_GREEN  = 8,
  parameter int unsigned MIN_YELLOW = 2,
  parameter int unsigned MAX_STALL  = 64,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       CLK100MHZ,
  input  logic       reset,
  input  logic       tick,
  input  logic       clr,
  input  logic [7:0] lamps,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [7:0] fault_count,
  output logic       armed
);

  localparam logic [CNT_W-1:0] StallLimit = CNT_W'(MAX_STALL);

  logic [7:0]       lamps_q;
  logic [5:0]       lamps_p;
  mon_state_t       state_q, state_d;
  logic             fault_q, fault_d;
  fault_code_t      code_q, code_d;
  logic [7:0]       count_q, count_d;
  logic [CNT_W-1:0] stall_cnt;

  logic        trk_clear;
  logic        chg_a, seq_a, short_a, combo_a;
  logic        chg_b, seq_b, short_b, combo_b;
  logic        conflict_err, ped_err, stall_err;
  fault_code_t static_code, run_code;

  assign trk_clear = (state_q != ST_RUN) || clr;

  semaforo_phase_tracker #(
    .MIN_GREEN (MIN_GREEN),
    .MIN_YELLOW(MIN_YELLOW),
    .CNT_W     (CNT_W)
  ) u_track_a (
    .clk      (CLK100MHZ),
    .reset    (reset),
    .clear    (trk_clear),
    .tick     (tick),
    .ryg_now  ({lamps_q[LAMP_G_A], lamps_q[LAMP_Y_A], lamps_q[LAMP_R_A]}),
    .ryg_prev ({lamps_p[LAMP_G_A], lamps_p[LAMP_Y_A], lamps_p[LAMP_R_A]}),
    .changed  (chg_a),
    .seq_err  (seq_a),
    .short_err(short_a),
    .combo_err(combo_a)
  );

  semaforo_phase_tracker #(
    .MIN_GREEN (MIN_GREEN),
    .MIN_YELLOW(MIN_YELLOW),
    .CNT_W     (CNT_W)
  ) u_track_b (
    .clk      (CLK100MHZ),
    .reset    (reset),
    .clear    (trk_clear),
    .tick     (tick),
    .ryg_now  ({lamps_q[LAMP_G_B], lamps_q[LAMP_Y_B], lamps_q[LAMP_R_B]}),
    .ryg_prev ({lamps_p[LAMP_G_B], lamps_p[LAMP_Y_B], lamps_p[LAMP_R_B]}),
    .changed  (chg_b),
    .seq_err  (seq_b),
    .short_err(short_b),
    .combo_err(combo_b)
  );

  // Lamp capture: plain data pipeline, so the INIT baseline is valid right after reset
  always_ff @(posedge CLK100MHZ) begin
    lamps_q <= lamps;
    lamps_p <= lamps_q[5:0];
  end

  // Progress watchdog: only vehicle lamps count as progress, ped lamps do not
  always_ff @(posedge CLK100MHZ) begin
    if (reset || trk_clear || chg_a || chg_b) begin
      stall_cnt <= '0;
    end else if (tick && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // Static checks and priority encode; static_code alone judges the INIT baseline
  always_comb begin
    conflict_err = (lamps_q[LAMP_G_A] | lamps_q[LAMP_Y_A]) &
                   (lamps_q[LAMP_G_B] | lamps_q[LAMP_Y_B]);
    ped_err      = (lamps_q[LAMP_PED_A] & ~lamps_q[LAMP_R_A]) |
                   (lamps_q[LAMP_PED_B] & ~lamps_q[LAMP_R_B]);
    stall_err    = (stall_cnt == StallLimit);

    static_code = FC_NONE;
    if (conflict_err)          static_code = FC_CONFLICT;
    else if (combo_a | combo_b) static_code = FC_COMBO;
    else if (ped_err)          static_code = FC_PED;

    run_code = static_code;
    if (static_code == FC_NONE) begin
      if (seq_a | seq_b)          run_code = FC_SEQ;
      else if (short_a | short_b) run_code = FC_SHORT;
      else if (stall_err)         run_code = FC_STALL;
    end
  end

  // Monitor FSM: INIT (baseline) -> RUN -> FAULT, clr returns to INIT from anywhere
  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    code_d  = code_q;
    count_d = count_q;
    case (state_q)
      ST_INIT: begin
        if (!clr) begin
          if (static_code != FC_NONE) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
            code_d  = static_code;
            if (count_q != 8'hFF) count_d = count_q + 8'd1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (clr) begin
          state_d = ST_INIT;
        end else if (run_code != FC_NONE) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
          code_d  = run_code;
          if (count_q != 8'hFF) count_d = count_q + 8'd1;
        end
      end
      ST_FAULT: begin
        if (clr) begin
          state_d = ST_INIT;
          fault_d = 1'b0;
          code_d  = FC_NONE;
        end
      end
      default: begin
        state_d = ST_INIT;
        fault_d = 1'b0;
        code_d  = FC_NONE;
      end
    endcase
  end

  // State registers; reset dominates clr and every other input
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_q <= ST_INIT;
      fault_q <= 1'b0;
      code_q  <= FC_NONE;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      count_q <= count_d;
    end
  end

  assign fault       = fault_q;
  assign fault_code  = code_q;
  assign fault_count = count_q;
  assign armed       = (state_q == ST_RUN);

endmodule

// File: tb/tb_semaforo_monitor.sv
// Directed bench for semaforo_monitor: legal cycling, each fault class, priority,
// clr/reset behaviour and fault_count saturation.
module tb_semaforo_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] lamps = 8'h0C;
  logic       fault;
  logic [2:0] fault_code;
  logic [7:0] fault_count;
  logic       armed;

  int total = 0;
  int bad   = 0;

  // Lamp patterns {ped_b,ped_a,g_b,y_b,r_b,g_a,y_a,r_a}
  localparam logic [7:0] AG_BR = 8'h0C;
  localparam logic [7:0] AY_BR = 8'h0A;
  localparam logic [7:0] AR_BG = 8'h21;
  localparam logic [7:0] AR_BY = 8'h11;
  localparam logic [7:0] AR_BR = 8'h09;
  localparam logic [7:0] ARY_BR = 8'h0B;
  localparam logic [7:0] AG_BG = 8'h24;
  localparam logic [7:0] PEDA_AG = 8'h4C;

  semaforo_monitor #(
    .MIN_GREEN (4),
    .MIN_YELLOW(2),
    .MAX_STALL (20),
    .CNT_W     (8)
  ) dut (
    .CLK100MHZ  (clk),
    .reset      (reset),
    .tick       (tick),
    .clr        (clr),
    .lamps      (lamps),
    .fault      (fault),
    .fault_code (fault_code),
    .fault_count(fault_count),
    .armed      (armed)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock; inputs changed after this return are "driven at" the edge just passed
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One prescaler period of 4 cycles, tick sampled on the last edge
  task automatic tick_once();
    cyc();
    cyc();
    cyc();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick_once();
  endtask

  task automatic clear_to_run(input logic [7:0] l);
    lamps = l;
    clr   = 1'b1;
    cyc();
    clr   = 1'b0;
    cyc();
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    lamps = AG_BR;
    cyc();
    cyc();
    check_eq("rst_fault", fault, 0);
    check_eq("rst_code", fault_code, 0);
    check_eq("rst_count", fault_count, 0);
    check_eq("rst_armed", armed, 0);
    reset = 1'b0;
    cyc();
    check_eq("init_to_run", armed, 1);

    // 1: three legal loops
    for (int loop = 0; loop < 3; loop++) begin
      lamps = AG_BR; if (loop != 0) cyc(); ticks(5);
      check_eq($sformatf("legal_ag_fault%0d", loop), fault, 0);
      lamps = AY_BR; ticks(2);
      check_eq($sformatf("legal_ay_fault%0d", loop), fault, 0);
      lamps = AR_BG; ticks(5);
      check_eq($sformatf("legal_bg_armed%0d", loop), armed, 1);
      lamps = AR_BY; ticks(2);
      check_eq($sformatf("legal_by_fault%0d", loop), fault, 0);
    end
    cyc();
    cyc();
    check_eq("legal_end_fault", fault, 0);
    check_eq("legal_end_armed", armed, 1);

    // 2: conflict, two-edge latency
    lamps = AG_BG;
    cyc();
    check_eq("conf_lat_fault", fault, 0);
    cyc();
    check_eq("conf_fault", fault, 1);
    check_eq("conf_code", fault_code, 1);
    check_eq("conf_count", fault_count, 1);
    check_eq("conf_armed", armed, 0);

    // 3: short green, then clr
    reset = 1'b1; lamps = AG_BR; cyc(); reset = 1'b0; cyc();
    ticks(3);
    lamps = AY_BR;
    cyc();
    cyc();
    check_eq("short_code", fault_code, 5);
    check_eq("short_count", fault_count, 1);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    check_eq("clr_init_armed", armed, 0);
    check_eq("clr_init_fault", fault, 0);
    cyc();
    check_eq("clr_run_armed", armed, 1);
    check_eq("clr_code", fault_code, 0);
    check_eq("clr_count_kept", fault_count, 1);

    // 4: G->R skipping yellow, then combo beating seq
    reset = 1'b1; lamps = AG_BR; cyc(); reset = 1'b0; cyc();
    ticks(5);
    lamps = AR_BR;
    cyc();
    cyc();
    check_eq("seq_code", fault_code, 4);
    clear_to_run(AR_BR);
    lamps = AG_BR;
    ticks(5);
    check_eq("seq_rearm", armed, 1);
    lamps = ARY_BR;
    cyc();
    cyc();
    check_eq("combo_code", fault_code, 2);
    check_eq("combo_count", fault_count, 2);

    // 5: stall with ped_b toggling
    clear_to_run(AG_BR);
    for (int i = 0; i < 19; i++) begin
      lamps = lamps ^ 8'h80;
      tick_once();
    end
    check_eq("stall19_fault", fault, 0);
    check_eq("stall19_armed", armed, 1);
    lamps = lamps ^ 8'h80;
    tick_once();
    cyc();
    check_eq("stall_fault", fault, 1);
    check_eq("stall_code", fault_code, 6);
    check_eq("stall_count", fault_count, 3);

    // 6: ped, reset mid-fault, saturation
    clear_to_run(AG_BR);
    lamps = PEDA_AG;
    cyc();
    cyc();
    check_eq("ped_code", fault_code, 3);
    check_eq("ped_count", fault_count, 4);
    reset = 1'b1;
    clr   = 1'b1;
    cyc();
    clr   = 1'b0;
    check_eq("rst2_fault", fault, 0);
    check_eq("rst2_code", fault_code, 0);
    check_eq("rst2_count", fault_count, 0);
    check_eq("rst2_armed", armed, 0);
    reset = 1'b0;
    lamps = AG_BR;
    cyc();
    for (int i = 1; i <= 257; i++) begin
      lamps = PEDA_AG;
      cyc();
      cyc();
      if (i == 1 || i == 254 || i == 255 || i == 256 || i == 257) begin
        check_eq($sformatf("sat_count%0d", i), fault_count, (i > 255) ? 255 : i);
      end
      clear_to_run(AG_BR);
    end
    check_eq("sat_after_clr", fault_count, 255);
    check_eq("sat_armed", armed, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
